// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-beat AXI4 master port between an
// instruction-refill requester (port 0) and a data refill/writeback requester (port 1).
module mem_port_arbiter #(
    parameter int ADDR_W = 27,
    parameter int DATA_W = 128
) (
    input  logic                ACLK,
    input  logic                ARESET,

    input  logic                p0_req,
    input  logic                p0_we,
    input  logic [ADDR_W-1:0]   p0_addr,
    input  logic [DATA_W-1:0]   p0_wdata,
    output logic                p0_done,
    output logic                p0_err,

    input  logic                p1_req,
    input  logic                p1_we,
    input  logic [ADDR_W-1:0]   p1_addr,
    input  logic [DATA_W-1:0]   p1_wdata,
    output logic                p1_done,
    output logic                p1_err,

    output logic [DATA_W-1:0]   rdata,

    output logic [3:0]          M_AXI_AWID,
    output logic [ADDR_W-1:0]   M_AXI_AWADDR,
    output logic [7:0]          M_AXI_AWLEN,
    output logic [2:0]          M_AXI_AWSIZE,
    output logic [1:0]          M_AXI_AWBURST,
    output logic                M_AXI_AWLOCK,
    output logic [3:0]          M_AXI_AWCACHE,
    output logic [2:0]          M_AXI_AWPROT,
    output logic [3:0]          M_AXI_AWQOS,
    output logic                M_AXI_AWVALID,
    input  logic                M_AXI_AWREADY,

    output logic [DATA_W-1:0]   M_AXI_WDATA,
    output logic [DATA_W/8-1:0] M_AXI_WSTRB,
    output logic                M_AXI_WLAST,
    output logic                M_AXI_WVALID,
    input  logic                M_AXI_WREADY,

    input  logic [1:0]          M_AXI_BRESP,
    input  logic                M_AXI_BVALID,
    output logic                M_AXI_BREADY,

    output logic [3:0]          M_AXI_ARID,
    output logic [ADDR_W-1:0]   M_AXI_ARADDR,
    output logic [7:0]          M_AXI_ARLEN,
    output logic [2:0]          M_AXI_ARSIZE,
    output logic [1:0]          M_AXI_ARBURST,
    output logic                M_AXI_ARLOCK,
    output logic [3:0]          M_AXI_ARCACHE,
    output logic [2:0]          M_AXI_ARPROT,
    output logic [3:0]          M_AXI_ARQOS,
    output logic                M_AXI_ARVALID,
    input  logic                M_AXI_ARREADY,

    input  logic [DATA_W-1:0]   M_AXI_RDATA,
    input  logic [1:0]          M_AXI_RRESP,
    input  logic                M_AXI_RLAST,
    input  logic                M_AXI_RVALID,
    output logic                M_AXI_RREADY
);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE} state_e;

    state_e              state_q, state_d;
    logic                ptr_q, ptr_d;
    logic                gnt_q, gnt_d;
    logic                err_q, err_d;
    logic                aw_pend_q, aw_pend_d;
    logic                w_pend_q, w_pend_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                sel;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;

    // Single-beat bursts: RLAST carries no information, and the low address
    // nibble is replaced by zeros.
    logic                unused_inputs;
    assign unused_inputs = ^{M_AXI_RLAST, p0_addr[3:0], p1_addr[3:0]};

    // On a tie the port that did not win last time goes; ptr_q holds the last winner.
    assign sel      = p1_req & (~p0_req | ~ptr_q);
    assign sel_we   = sel ? p1_we : p0_we;
    assign sel_addr = sel ? p1_addr : p0_addr;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        err_d     = err_q;
        aw_pend_d = aw_pend_q;
        w_pend_d  = w_pend_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        case (state_q)
            IDLE: begin
                if (p0_req | p1_req) begin
                    gnt_d   = sel;
                    ptr_d   = sel;
                    addr_d  = {sel_addr[ADDR_W-1:4], 4'b0000};
                    wdata_d = sel ? p1_wdata : p0_wdata;
                    if (sel_we) begin
                        state_d   = WR_REQ;
                        aw_pend_d = 1'b1;
                        w_pend_d  = 1'b1;
                    end else begin
                        state_d = RD_ADDR;
                    end
                end
            end
            RD_ADDR: begin
                if (M_AXI_ARREADY) state_d = RD_DATA;
            end
            RD_DATA: begin
                if (M_AXI_RVALID) begin
                    rdata_d = M_AXI_RDATA;
                    err_d   = |M_AXI_RRESP;
                    state_d = DONE;
                end
            end
            WR_REQ: begin
                // AW and W retire independently; leave once neither is outstanding.
                if (M_AXI_AWREADY) aw_pend_d = 1'b0;
                if (M_AXI_WREADY)  w_pend_d  = 1'b0;
                if ((~aw_pend_q | M_AXI_AWREADY) & (~w_pend_q | M_AXI_WREADY))
                    state_d = WR_RESP;
            end
            WR_RESP: begin
                if (M_AXI_BVALID) begin
                    err_d   = |M_AXI_BRESP;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q   <= IDLE;
            ptr_q     <= 1'b1;
            gnt_q     <= 1'b0;
            err_q     <= 1'b0;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            err_q     <= err_d;
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
        end
    end

    assign M_AXI_ARVALID = (state_q == RD_ADDR);
    assign M_AXI_RREADY  = (state_q == RD_DATA);
    assign M_AXI_AWVALID = (state_q == WR_REQ) & aw_pend_q;
    assign M_AXI_WVALID  = (state_q == WR_REQ) & w_pend_q;
    assign M_AXI_BREADY  = (state_q == WR_RESP);

    assign p0_done = (state_q == DONE) & ~gnt_q;
    assign p1_done = (state_q == DONE) &  gnt_q;
    assign p0_err  = p0_done & err_q;
    assign p1_err  = p1_done & err_q;
    assign rdata   = rdata_q;

    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_WDATA   = wdata_q;

    assign M_AXI_AWID    = '0;
    assign M_AXI_AWLEN   = '0;
    assign M_AXI_AWSIZE  = 3'b100;
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_AWLOCK  = 1'b0;
    assign M_AXI_AWCACHE = '0;
    assign M_AXI_AWPROT  = '0;
    assign M_AXI_AWQOS   = '0;
    assign M_AXI_ARID    = '0;
    assign M_AXI_ARLEN   = '0;
    assign M_AXI_ARSIZE  = 3'b100;
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARCACHE = '0;
    assign M_AXI_ARPROT  = '0;
    assign M_AXI_ARQOS   = '0;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WLAST   = 1'b1;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a table of single transfers against a
// configurable-latency AXI slave, plus arbitration and reset sequences.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 27;
    localparam int DATA_W = 128;

    logic ACLK = 1'b0;
    logic ARESET;
    logic p0_req, p0_we, p0_done, p0_err;
    logic p1_req, p1_we, p1_done, p1_err;
    logic [ADDR_W-1:0] p0_addr, p1_addr;
    logic [DATA_W-1:0] p0_wdata, p1_wdata, rdata;
    logic [3:0] awid, arid, awcache, arcache, awqos, arqos;
    logic [7:0] awlen, arlen;
    logic [2:0] awsize, arsize, awprot, arprot;
    logic [1:0] awburst, arburst;
    logic awlock, arlock;
    logic [ADDR_W-1:0] M_AXI_AWADDR, M_AXI_ARADDR;
    logic M_AXI_AWVALID, M_AXI_AWREADY, M_AXI_WVALID, M_AXI_WREADY, M_AXI_WLAST;
    logic [DATA_W-1:0] M_AXI_WDATA, M_AXI_RDATA;
    logic [DATA_W/8-1:0] M_AXI_WSTRB;
    logic [1:0] M_AXI_BRESP, M_AXI_RRESP;
    logic M_AXI_BVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_ARREADY;
    logic M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY;

    always #5 ACLK = ~ACLK;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_done(p0_done), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_done(p1_done), .p1_err(p1_err),
        .rdata(rdata),
        .M_AXI_AWID(awid), .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(awlen),
        .M_AXI_AWSIZE(awsize), .M_AXI_AWBURST(awburst), .M_AXI_AWLOCK(awlock),
        .M_AXI_AWCACHE(awcache), .M_AXI_AWPROT(awprot), .M_AXI_AWQOS(awqos),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY),
        .M_AXI_ARID(arid), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(arlen),
        .M_AXI_ARSIZE(arsize), .M_AXI_ARBURST(arburst), .M_AXI_ARLOCK(arlock),
        .M_AXI_ARCACHE(arcache), .M_AXI_ARPROT(arprot), .M_AXI_ARQOS(arqos),
        .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
        .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RLAST(M_AXI_RLAST),
        .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY)
    );

    // Slave model: each READY/VALID is withheld for *_dly cycles of the master's request.
    int ar_dly, r_dly, aw_dly, w_dly, b_dly;
    int arc, rc, awc, wc, bc;
    logic [DATA_W-1:0] rdata_cfg;
    logic [1:0] resp_cfg;

    always @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            arc <= 0; rc <= 0; awc <= 0; wc <= 0; bc <= 0;
        end else begin
            if (M_AXI_ARVALID && M_AXI_ARREADY) arc <= 0; else if (M_AXI_ARVALID) arc <= arc + 1;
            if (M_AXI_RREADY && M_AXI_RVALID)   rc  <= 0; else if (M_AXI_RREADY)  rc  <= rc + 1;
            if (M_AXI_AWVALID && M_AXI_AWREADY) awc <= 0; else if (M_AXI_AWVALID) awc <= awc + 1;
            if (M_AXI_WVALID && M_AXI_WREADY)   wc  <= 0; else if (M_AXI_WVALID)  wc  <= wc + 1;
            if (M_AXI_BREADY && M_AXI_BVALID)   bc  <= 0; else if (M_AXI_BREADY)  bc  <= bc + 1;
        end
    end

    always @(negedge ACLK) begin
        M_AXI_ARREADY = M_AXI_ARVALID && (arc >= ar_dly);
        M_AXI_RVALID  = M_AXI_RREADY  && (rc  >= r_dly);
        M_AXI_AWREADY = M_AXI_AWVALID && (awc >= aw_dly);
        M_AXI_WREADY  = M_AXI_WVALID  && (wc  >= w_dly);
        M_AXI_BVALID  = M_AXI_BREADY  && (bc  >= b_dly);
        M_AXI_RDATA   = rdata_cfg;
        M_AXI_RRESP   = resp_cfg;
        M_AXI_BRESP   = resp_cfg;
        M_AXI_RLAST   = 1'b1;
    end

    typedef struct {
        int                port;
        bit                we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] rdata;
        logic [1:0]        resp;
        int                ar, r, aw, w, b;
        logic [ADDR_W-1:0] exp_addr;
        bit                exp_err;
        int                exp_lat;
        int                exp_arv, exp_awv, exp_wv;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Drives one transfer from an IDLE negedge and returns at the IDLE negedge after done.
    task automatic run_txn(input vec_t v, input int idx);
        int cyc = 0, arv = 0, awv = 0, wv = 0, other = 0;
        int addr_bad = 0, wd_bad = 0, br_bad = 0, err_bad = 0;
        bit got = 0;
        logic err_seen;
        ar_dly = v.ar; r_dly = v.r; aw_dly = v.aw; w_dly = v.w; b_dly = v.b;
        rdata_cfg = v.rdata; resp_cfg = v.resp;
        if (v.port == 0) begin
            p0_we = v.we; p0_addr = v.addr; p0_wdata = v.wdata; p0_req = 1'b1;
        end else begin
            p1_we = v.we; p1_addr = v.addr; p1_wdata = v.wdata; p1_req = 1'b1;
        end
        while (!got && cyc < 100) begin
            @(posedge ACLK);
            cyc++;
            @(negedge ACLK);
            if (M_AXI_ARVALID) begin arv++; if (M_AXI_ARADDR !== v.exp_addr) addr_bad++; end
            if (M_AXI_AWVALID) begin awv++; if (M_AXI_AWADDR !== v.exp_addr) addr_bad++; end
            if (M_AXI_WVALID)  begin wv++;  if (M_AXI_WDATA !== v.wdata) wd_bad++; end
            if (M_AXI_BREADY && (M_AXI_AWVALID || M_AXI_WVALID)) br_bad++;
            if ((p0_err && !p0_done) || (p1_err && !p1_done)) err_bad++;
            if ((v.port == 0) ? p1_done : p0_done) other++;
            if ((v.port == 0) ? p0_done : p1_done) got = 1;
        end
        chk($sformatf("v%0d done_seen", idx), got, 1'b1);
        if (got) begin
            err_seen = (v.port == 0) ? p0_err : p1_err;
            chk($sformatf("v%0d latency", idx), cyc, v.exp_lat);
            chk($sformatf("v%0d err", idx), err_seen, v.exp_err);
            if (!v.we) chk($sformatf("v%0d rdata", idx), rdata, v.rdata);
        end
        if (v.we) begin
            chk($sformatf("v%0d awvalid_cycles", idx), awv, v.exp_awv);
            chk($sformatf("v%0d wvalid_cycles", idx), wv, v.exp_wv);
            chk($sformatf("v%0d wdata_unstable", idx), wd_bad, 0);
            chk($sformatf("v%0d bready_early", idx), br_bad, 0);
            chk($sformatf("v%0d arvalid_cycles", idx), arv, 0);
        end else begin
            chk($sformatf("v%0d arvalid_cycles", idx), arv, v.exp_arv);
            chk($sformatf("v%0d aw_w_cycles", idx), awv + wv, 0);
        end
        chk($sformatf("v%0d addr_bad", idx), addr_bad, 0);
        chk($sformatf("v%0d other_done", idx), other, 0);
        chk($sformatf("v%0d err_without_done", idx), err_bad, 0);
        p0_req = 1'b0; p1_req = 1'b0;
        @(negedge ACLK);
        chk($sformatf("v%0d done_one_cycle", idx), {p0_done, p1_done, p0_err, p1_err}, 4'b0);
    endtask

    vec_t vecs[8];
    int order[4];

    initial begin
        int n, cyc;
        bit r0, r1, saw_rready;

        vecs[0] = '{0, 0, 27'h0001230, '0, {16{8'hA5}}, 2'b00, 0, 2, 0, 0, 0,
                    27'h0001230, 0, 5, 1, 0, 0};
        vecs[1] = '{1, 1, 27'h0000FFF, 128'h123456789ABCDEF0_0FEDCBA987654321, '0, 2'b00,
                    0, 0, 0, 3, 0, 27'h0000FF0, 0, 6, 0, 1, 4};
        vecs[2] = '{0, 0, 27'h0ABCDEF, '0, 128'hDEADBEEF_00000000_11111111_CAFEF00D, 2'b10,
                    0, 0, 0, 0, 0, 27'h0ABCDE0, 1, 3, 1, 0, 0};
        vecs[3] = '{1, 1, 27'h7FFFFFF, 128'hFFFF0000_FFFF0000_0000FFFF_0000FFFF, '0, 2'b11,
                    0, 0, 2, 0, 1, 27'h7FFFFF0, 1, 6, 0, 3, 1};
        vecs[4] = '{1, 0, 27'h0000010, '0, 128'h01234567_89ABCDEF_FEDCBA98_76543210, 2'b00,
                    0, 0, 0, 0, 0, 27'h0000010, 0, 3, 1, 0, 0};
        vecs[5] = '{0, 1, 27'h4000008, 128'hCAFEBABE_0BADF00D_12345678_9ABCDEF0, '0, 2'b00,
                    0, 0, 1, 1, 0, 27'h4000000, 0, 4, 0, 2, 2};
        vecs[6] = '{0, 0, 27'h1111111, '0, {16{8'h5A}}, 2'b00, 10, 0, 0, 0, 0,
                    27'h1111110, 0, 13, 11, 0, 0};
        vecs[7] = '{1, 0, 27'h2222225, '0, {16{8'h0F}}, 2'b01, 1, 1, 0, 0, 0,
                    27'h2222220, 1, 5, 2, 0, 0};

        ARESET = 1'b1;
        p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
        ar_dly = 0; r_dly = 0; aw_dly = 0; w_dly = 0; b_dly = 0;
        rdata_cfg = '0; resp_cfg = 2'b00;
        repeat (3) @(negedge ACLK);

        chk("reset_handshake_outs",
            {M_AXI_ARVALID, M_AXI_RREADY, M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}, 5'b0);
        chk("reset_done_err", {p0_done, p1_done, p0_err, p1_err}, 4'b0);
        chk("reset_rdata", rdata, '0);
        chk("reset_addr_wdata", {M_AXI_ARADDR, M_AXI_AWADDR, M_AXI_WDATA}, '0);
        chk("const_size_burst_len", {arsize, awsize, arburst, awburst, arlen, awlen},
            {3'b100, 3'b100, 2'b01, 2'b01, 8'h00, 8'h00});
        chk("const_wstrb_wlast", {M_AXI_WSTRB, M_AXI_WLAST}, {{(DATA_W/8){1'b1}}, 1'b1});
        chk("const_misc_zero", {awid, arid, awlock, arlock, awcache, arcache,
                                awprot, arprot, awqos, arqos}, '0);
        ARESET = 1'b0;
        @(negedge ACLK);

        for (int i = 0; i < 8; i++) run_txn(vecs[i], i);

        // Both ports reading and re-requesting in the IDLE cycle right after their done.
        ar_dly = 0; r_dly = 0; resp_cfg = 2'b00; rdata_cfg = {4{32'h600DD00D}};
        p0_we = 0; p1_we = 0; p0_addr = 27'h0000100; p1_addr = 27'h0000200;
        p0_req = 1; p1_req = 1;
        n = 0; cyc = 0; r0 = 0; r1 = 0;
        while (n < 4 && cyc < 200) begin
            @(posedge ACLK);
            cyc++;
            @(negedge ACLK);
            if (r0) begin p0_req = 1; r0 = 0; end
            if (r1) begin p1_req = 1; r1 = 0; end
            if (p0_done) begin order[n] = 0; n++; p0_req = 0; r0 = (n <= 2); end
            if (p1_done) begin order[n] = 1; n++; p1_req = 0; r1 = (n <= 2); end
        end
        chk("rr_grant_count", n, 4);
        chk("rr_grant0", order[0], 0);
        chk("rr_grant1", order[1], 1);
        chk("rr_grant2", order[2], 0);
        chk("rr_grant3", order[3], 1);
        p0_req = 0; p1_req = 0;
        @(negedge ACLK);

        // Async reset while the read sits in RD_DATA.
        r_dly = 30; p0_addr = 27'h0003330; p0_req = 1;
        saw_rready = 0;
        for (int k = 0; k < 20 && !saw_rready; k++) begin
            @(negedge ACLK);
            if (M_AXI_RREADY) saw_rready = 1;
        end
        chk("rst_reached_rd_data", saw_rready, 1'b1);
        #2 ARESET = 1'b1;
        #1;
        chk("rst_async_outputs", {M_AXI_ARVALID, M_AXI_RREADY, p0_done, p0_err}, 4'b0);
        chk("rst_async_rdata", rdata, '0);
        p0_req = 0;
        @(negedge ACLK);
        ARESET = 1'b0;

        // Fresh tie after reset: port 0 must win.
        r_dly = 0; rdata_cfg = {4{32'h0BEEF0A1}};
        p0_addr = 27'h0000440; p1_addr = 27'h0000880; p0_req = 1; p1_req = 1;
        cyc = 0;
        while (!p0_done && !p1_done && cyc < 50) begin
            @(posedge ACLK);
            cyc++;
            @(negedge ACLK);
        end
        chk("post_rst_p0_wins", {p0_done, p1_done}, 2'b10);
        chk("post_rst_latency", cyc, 3);
        chk("post_rst_rdata", rdata, {4{32'h0BEEF0A1}});
        p0_req = 0;
        cyc = 0;
        while (!p1_done && cyc < 50) begin
            @(posedge ACLK);
            cyc++;
            @(negedge ACLK);
        end
        chk("post_rst_p1_served", p1_done, 1'b1);
        p1_req = 0;
        @(negedge ACLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the cache's single AXI4 memory master port between two line-transfer requesters: port 0 (instruction-side refill) and port 1 (data-side refill/writeback). Each transfer is one 128-bit line in a single beat. The block arbitrates round-robin and sequences the AXI read (AR/R) or write (AW/W/B) handshake for the granted request. It returns read data, completion and error status to the originating port.

## Interface
- ADDR_W, 27, byte address width of requester and AXI addresses
- DATA_W, 128, line/beat width; WSTRB width is DATA_W/8
- ACLK  in  1  clock; all logic is rising-edge
- ARESET  in  1  asynchronous, active-high reset
- p0_req, p1_req  in  1 each  transfer request; held high until that port's done
- p0_we, p1_we  in  1 each  1 = write line, 0 = read line; stable while req is high
- p0_addr, p1_addr  in  ADDR_W each  line address; bits [3:0] are ignored and driven as 0
- p0_wdata, p1_wdata  in  DATA_W each  write line; stable while req is high
- p0_done, p1_done  out  1 each  one-cycle completion pulse
- p0_err, p1_err  out  1 each  valid with done; 1 if RRESP/BRESP != 2'b00
- rdata  out  DATA_W  captured read line; valid when a read's done is high, held until the next read capture
- M_AXI_AWADDR, M_AXI_ARADDR  out  ADDR_W  registered granted address
- M_AXI_AWVALID, M_AXI_AWREADY  out/in  1  write address handshake
- M_AXI_WDATA  out  DATA_W  registered granted wdata
- M_AXI_WVALID, M_AXI_WREADY  out/in  1  write data handshake
- M_AXI_BRESP, M_AXI_BVALID, M_AXI_BREADY  in/in/out  2/1/1  write response
- M_AXI_ARVALID, M_AXI_ARREADY  out/in  1  read address handshake
- M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID, M_AXI_RREADY  in/in/in/in/out  DATA_W/2/1/1/1  read data
- Constant outputs:
  - AWLEN/ARLEN = 0
  - AWSIZE/ARSIZE = 3'b100
  - AWBURST/ARBURST = 2'b01
  - WSTRB = all ones
  - WLAST = 1
  - AWID/ARID = 0; AWLOCK/ARLOCK/AWCACHE/ARCACHE/AWPROT/ARPROT/AWQOS/ARQOS = 0

## Operation
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, DONE.
- IDLE, arbitration:
  - With a req high, grant it. Latch the port id, we, addr (with [3:0] forced to 0) and wdata.
  - If both reqs are high, grant the port not granted last. The last-granted pointer resets to 1, so port 0 wins first.
  - Pointer updates on every grant.
- Read path:
  - IDLE → RD_ADDR: ARVALID=1 until ARREADY.
  - Then RD_DATA: RREADY=1. On RVALID, capture RDATA into rdata and set err = (RRESP != 0). RLAST is ignored.
  - Then go to DONE.
- Write path:
  - IDLE → WR_REQ: AWVALID and WVALID both rise. Each drops independently after its own handshake; the two may complete in either order or the same cycle.
  - When both handshakes are complete, go to WR_RESP: BREADY=1. On BVALID, set err = (BRESP != 0).
  - Then go to DONE.
- DONE: pulse the granted port's done/err for exactly one cycle, then return to IDLE. The granted port's req is not sampled in DONE.
- VALID signals never drop before their READY is seen.
- ADDR/WDATA are stable while VALID is high.

## Timing
- Reset (async assert): state = IDLE; all VALID/READY outputs = 0; done/err = 0; rdata = 0; address/wdata registers = 0; pointer = 1.
- Reset mid-transfer aborts the transfer immediately; the requester must reissue.
- req sampled high in IDLE at edge N → ARVALID or AWVALID/WVALID high from N+1.
- Read, ARREADY already high: ARVALID for 1 cycle; RREADY from N+2.
- RVALID&RREADY at edge M → done/rdata at M+1; IDLE at M+2; next grant visible at M+3.
- Minimum read with zero-wait slave: req edge to done = 3 cycles.
- Minimum write with zero-wait slave: req edge to done = 3 cycles (WR_REQ, WR_RESP, DONE).
- Requester observing done must have req low by the next IDLE sample edge (M+2).
- err is 0 whenever done is 0.

## Test plan
- Port-0 read of 0x0001230, slave ARREADY=1, RVALID 2 cycles later with RDATA=0xA5..A5, RRESP=0 → ARADDR=0x0001230 for 1 cycle; p0_done one cycle with rdata=0xA5..A5, p0_err=0; p1_done never.
- p0_req and p1_req (both reads) high in the same cycle after reset, each re-requesting immediately → grants in the order p0, p1, p0, p1; no port serviced twice in a row while both are requesting.
- p1 write addr=0x0000FFF, wdata=0x1234…, AWREADY immediate, WREADY delayed 3 cycles → AWADDR=0x0000FF0; AWVALID drops after 1 cycle; WVALID held 4 cycles with stable data; BREADY only after both handshakes; p1_done after BVALID.
- Read with RRESP=2'b10 and write with BRESP=2'b11 → done pulses with err=1; next transfer with OKAY has err=0.
- ARESET asserted while in RD_DATA → ARVALID/RREADY/done low in the same cycle (asynchronously). After release, a fresh p0 read completes normally with port 0 winning a tie.
- ARREADY held low 10 cycles → ARVALID and ARADDR stay constant for all 10 cycles; no done until after R.
